mult32_seq: RTL and testbench

- Sequential unsigned shift-add multiplier for the MIPS ALU, serving MULTU and producing the HI/LO pair.
- Sits directly downstream of the bitwise AND stage. Each iteration's partial product is the multiplicand ANDed with a replicated multiplier bit, so it consumes the AND stage's output.
- Uses a start/busy/done handshake so the ALU control can stall while it runs.

---
 rtl/alu_pkg.sv | 16 +
 rtl/partial_product_gen.sv | 17 +
 rtl/mult32_seq.sv | 108 ++++++++++
 tb/tb_mult32_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and multiplier state encoding
//
// Purpose : common definitions for the ALU datapath blocks.
// Contents: default operand/counter widths, multiplier FSM state type.
package alu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/partial_product_gen.sv
// rtl/partial_product_gen.sv - bitwise AND stage producing one partial product
//
// Purpose : y = a & b, WIDTH bits wide. The multiplier feeds it the
//           multiplicand and the current multiplier bit replicated.
// Ports   : a, b  in  WIDTH  operands
//           y     out WIDTH  bitwise AND
module partial_product_gen #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = a & b;

endmodule

// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - sequential unsigned shift-add multiplier (MULTU, HI/LO)
//
// Purpose : one multiplier bit per cycle; WIDTH iterations per product.
// Ports   : clk         in  1      rising-edge clock
//           rst_n       in  1      asynchronous active-low reset
//           start       in  1      request; accepted in IDLE or DONE
//           a, b        in  WIDTH  multiplicand / multiplier, captured on accept
//           busy        out 1      high while iterating
//           done        out 1      one-cycle pulse, hi/lo valid
//           hi, lo      out WIDTH  registered product halves
module mult32_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   mult_state_t state, state_next;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mplr;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] pp;
   logic [WIDTH:0]   sum;
   logic             accept;
   logic             last_iter;
   logic             done_q;

   partial_product_gen #(.WIDTH(WIDTH)) u_pp (
      .a (mcand),
      .b ({WIDTH{mplr[0]}}),
      .y (pp)
   );

   // Carry out of the add lands in sum[WIDTH] and becomes acc's new MSB.
   assign sum       = {1'b0, acc} + {1'b0, pp};
   assign last_iter = (cnt == LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy   = (state == RUN);
      accept = start && ((state == IDLE) || (state == DONE));
      done   = done_q;
   end

   // Datapath: {acc,mplr} shift right by one each iteration with the sum on top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         acc    <= '0;
         mplr   <= '0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_next == DONE);
         if (accept) begin
            mcand <= a;
            acc   <= '0;
            mplr  <= b;
            cnt   <= '0;
         end else if (state == RUN) begin
            acc  <= sum[WIDTH:1];
            mplr <= {sum[0], mplr[WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
            if (last_iter) begin
               hi <= sum[WIDTH:1];
               lo <= {sum[0], mplr[WIDTH-1:1]};
            end
         end
      end
   end

endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - directed self-checking bench for mult32_seq
module tb_mult32_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_bad = 0;

   mult32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic launch(input logic [31:0] va, input logic [31:0] vb);
      start = 1'b1;
      a     = va;
      b     = vb;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Waits for done from the negedge after acceptance. Optionally pulses a
   // stray start with a=7,b=7 at iteration mid_at. Returns at the done negedge.
   task automatic wait_done(input string tag, input int mid_at,
                            output int edges, output int busy_cnt);
      logic [63:0] held;
      int          moved;
      held     = {hi, lo};
      moved    = 0;
      edges    = 0;
      busy_cnt = int'(busy);
      while (!done && edges < 100) begin
         if (edges == mid_at) begin
            start = 1'b1;
            a     = 32'd7;
            b     = 32'd7;
         end else if (edges == mid_at + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         edges++;
         if (!done) begin
            busy_cnt += int'(busy);
            if ({hi, lo} !== held) moved++;
         end
      end
      start = 1'b0;
      chk({tag, ".done_seen"}, 64'(done), 64'd1);
      chk({tag, ".hilo_hold"}, 64'(moved), 64'd0);
   endtask

   task automatic check_op(input string tag, input logic [63:0] exp,
                           input int mid_at, input bit tail);
      int edges, busy_cnt;
      wait_done(tag, mid_at, edges, busy_cnt);
      chk({tag, ".latency"}, 64'(edges), 64'd32);
      chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd32);
      chk({tag, ".product"}, {hi, lo}, exp);
      if (tail) begin
         @(negedge clk);
         chk({tag, ".done_pulse"}, 64'(done), 64'd0);
         chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int extra;

      repeat (3) @(negedge clk);
      chk("rst.outputs", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle.outputs", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);

      launch(32'd3, 32'd5);
      check_op("t1_3x5", 64'h0000_0000_0000_000F, -1, 1'b1);

      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_op("t2_max", 64'hFFFF_FFFE_0000_0001, -1, 1'b1);

      launch(32'hFFFF_FFFF, 32'd2);
      check_op("t2_max_x2", 64'h0000_0001_FFFF_FFFE, -1, 1'b1);

      launch(32'h8000_0000, 32'd2);
      check_op("t3_ignore", 64'h0000_0001_0000_0000, 10, 1'b1);
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         extra += int'(done) + int'(busy);
      end
      chk("t3.no_second_op", 64'(extra), 64'd0);

      // Abort mid-run: hi/lo currently hold 1:0 from the previous product.
      launch(32'hDEAD_BEEF, 32'd3);
      repeat (16) @(negedge clk);
      chk("t5.busy_before_rst", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5.async_clear", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         extra += int'(done);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         extra += int'(done) + int'(busy);
      end
      chk("t5.no_done_after_abort", 64'(extra), 64'd0);

      launch(32'h0000_1234, 32'h0000_0010);
      check_op("t5_post_rst", 64'h0000_0000_0001_2340, -1, 1'b1);

      // Back-to-back: start held high in the DONE cycle.
      launch(32'h0001_0000, 32'h0001_0000);
      check_op("t4_first", 64'h0000_0001_0000_0000, -1, 1'b0);
      launch(32'h0000_0000, 32'h1234_5678);
      chk("t4.busy_reassert", 64'(busy), 64'd1);
      chk("t4.done_dropped", 64'(done), 64'd0);
      chk("t4.hilo_kept", {hi, lo}, 64'h0000_0001_0000_0000);
      check_op("t4_second", 64'h0, -1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
